// File: rtl/qpsk_frame_sync_if.sv
// qpsk_frame_sync_if: byte stream handshake toward the packet/MAC layer.
// master drives data/valid, slave drives ready.
interface qpsk_frame_sync_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync: sync-word hunt, payload byte packing, output FIFO.
// Optional macro SYNC_INVERT_EN adds inverted-sync (180 deg) locking.
module qpsk_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'h1ACF,
  parameter int          PAYLOAD_BYTES = 4,
  parameter int          MAX_ERR       = 0,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_valid,
  input  logic i_bit,
  input  logic q_bit,
  qpsk_frame_sync_if.master bus,
  output logic frame_start,
  output logic frame_end,
  output logic locked,
  output logic overflow,
  input  logic clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(PAYLOAD_BYTES - 1);
  localparam logic [4:0] ME = 5'(MAX_ERR);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] sr_q;
  logic [15:0] sr_new;
  logic [7:0]  acc_q;
  logic [7:0]  acc_new;
  logic [1:0]  sym_cnt_q;
  logic [7:0]  byte_cnt_q;
  logic [1:0]  d;
  logic        hit_t;
  logic        hit;
  logic        sync_hit;
  logic        byte_done;
  logic        last;
  logic [7:0]  push_byte;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) begin
      n = n + {4'd0, v[k]};
    end
    return n;
  endfunction

  assign d       = {i_bit, q_bit};
  assign sr_new  = {sr_q[13:0], d};
  assign acc_new = {acc_q[5:0], d};
  assign hit_t   = popcnt(sr_new ^ SYNC_WORD) <= ME;

`ifdef SYNC_INVERT_EN
  logic inv_q;
  logic hit_i;

  assign hit_i     = popcnt(sr_new ^ ~SYNC_WORD) <= ME;
  assign hit       = hit_t || hit_i;
  assign push_byte = acc_new ^ {8{inv_q}};

  // Invert flag: true pattern wins; cleared when the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (sync_hit) begin
      inv_q <= !hit_t;
    end else if (last) begin
      inv_q <= 1'b0;
    end
  end
`else
  assign hit       = hit_t;
  assign push_byte = acc_new;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-symbol events.
  always_comb begin
    state_d   = state_q;
    sync_hit  = 1'b0;
    byte_done = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (sym_valid && hit) begin
          sync_hit = 1'b1;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (sym_valid && sym_cnt_q == 2'd3) begin
          byte_done = 1'b1;
          if (byte_cnt_q == LAST) begin
            last    = 1'b1;
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign locked    = (state_q == PAYLOAD);
  assign frame_end = last;

  // Shift register, accumulator and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      acc_q       <= '0;
      sym_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= sync_hit;
      if (state_q == HUNT && sym_valid) begin
        sr_q <= sr_new;
      end
      if (sync_hit) begin
        sym_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end
      if (state_q == PAYLOAD && sym_valid) begin
        acc_q     <= acc_new;
        sym_cnt_q <= sym_cnt_q + 2'd1;
      end
      if (byte_done) begin
        byte_cnt_q <= byte_cnt_q + 8'd1;
      end
      if (last) begin
        sr_q       <= '0;
        byte_cnt_q <= '0;
      end
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && bus.byte_ready;
  assign push_ok = byte_done && (!full || pop);
  assign drop    = byte_done && full && !pop;

  assign bus.byte_valid = !empty;
  assign bus.byte_data  = empty ? 8'h00 : mem[rptr_q[AW-1:0]];

  // FIFO storage; contents are meaningless once pointers reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q[AW-1:0]] <= push_byte;
    end
  end

  // FIFO pointers and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// tb_qpsk_frame_sync: random/directed stimulus, reference model, scoreboard.
// Optional macro SYNC_INVERT_EN selects the inverted-sync expectations.
module tb_qpsk_frame_sync;

  localparam int SYNC_I  = 'h1ACF;
  localparam int NSYNC_I = SYNC_I ^ 'hFFFF;
  localparam int PB      = 4;
  localparam int ME      = 0;
  localparam int DEPTH   = 4;
`ifdef SYNC_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_valid = 1'b0;
  logic i_bit = 1'b0;
  logic q_bit = 1'b0;
  logic clr_overflow = 1'b0;
  logic fs0, fe0, lk0, ov0;
  logic fs1, fe1, lk1, ov1;

  qpsk_frame_sync_if bus0 ();
  qpsk_frame_sync_if bus1 ();

  assign bus1.byte_ready = 1'b1;

  always #5 clk = ~clk;

  qpsk_frame_sync dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid),
    .i_bit(i_bit), .q_bit(q_bit), .bus(bus0),
    .frame_start(fs0), .frame_end(fe0), .locked(lk0),
    .overflow(ov0), .clr_overflow(clr_overflow)
  );

  qpsk_frame_sync #(.MAX_ERR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid),
    .i_bit(i_bit), .q_bit(q_bit), .bus(bus1),
    .frame_start(fs1), .frame_end(fe1), .locked(lk1),
    .overflow(ov1), .clr_overflow(clr_overflow)
  );

  int checks = 0;
  int failures = 0;
  int fs1_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  int win, acc, nsym, nbytes, m_cnt, md, m_byte;
  bit m_lock, m_inv, m_fs, m_ovf, m_pop, m_push, m_drop;

  int gap_max = 0;
  bit rnd_rdy = 1'b0;

  function automatic int pc16(input int v);
    int n = 0;
    for (int k = 0; k < 16; k++) n += (v >> k) & 1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame rules plus FIFO occupancy, per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win = 0; acc = 0; nsym = 0; nbytes = 0; m_cnt = 0;
      m_lock = 0; m_inv = 0; m_fs = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_fs = 0; m_push = 0; m_drop = 0;
      m_pop = (m_cnt > 0) && bus0.byte_ready;
      if (sym_valid) begin
        md = int'(i_bit) * 2 + int'(q_bit);
        if (!m_lock) begin
          win = (win * 4 + md) % 65536;
          if (pc16(win ^ SYNC_I) <= ME) begin
            m_lock = 1; m_inv = 0; m_fs = 1; nsym = 0; nbytes = 0;
          end else if (INV_EN && pc16(win ^ NSYNC_I) <= ME) begin
            m_lock = 1; m_inv = 1; m_fs = 1; nsym = 0; nbytes = 0;
          end
        end else begin
          acc = (acc * 4 + md) % 256;
          nsym++;
          if (nsym == 4) begin
            nsym = 0;
            m_push = 1;
            m_byte = m_inv ? 255 - acc : acc;
            nbytes++;
            if (nbytes == PB) begin
              m_lock = 0; win = 0; m_inv = 0;
            end
          end
        end
      end
      if (m_push) begin
        if (m_cnt < DEPTH || m_pop) begin
          exp_q.push_back(8'(m_byte));
          m_cnt++;
        end else begin
          m_drop = 1;
        end
      end
      if (m_pop) m_cnt--;
      if (m_drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  end

  // Monitor: compare outputs mid-cycle, pop scoreboard on transfers.
  always @(negedge clk) begin
    chk("locked", lk0, m_lock);
    chk("frame_start", fs0, m_fs);
    chk("overflow", ov0, m_ovf);
    chk("byte_valid", bus0.byte_valid, m_cnt > 0);
    chk("frame_end", fe0, m_lock && sym_valid && nsym == 3 &&
        nbytes == PB - 1);
    if (rst_n && bus0.byte_valid && bus0.byte_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL byte_unexpected: got %0h expected none",
                 bus0.byte_data);
      end else begin
        chk("byte_data", bus0.byte_data, exp_q.pop_front());
      end
      rx_q.push_back(bus0.byte_data);
    end
    if (fs1) fs1_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus0.byte_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sym(input logic [1:0] dd, input bit pulse);
    sym_valid = 1'b1;
    i_bit = dd[1];
    q_bit = dd[0];
    if (pulse) bus0.byte_ready = 1'b1;
    tick();
    sym_valid = 1'b0;
    if (pulse) bus0.byte_ready = 1'b0;
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pulse);
    for (int k = 3; k >= 0; k--) sym(b[2*k+1 -: 2], pulse && k == 0);
  endtask

  task automatic send_sync(input logic [15:0] w);
    for (int k = 7; k >= 0; k--) sym(w[2*k+1 -: 2], 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] w, input logic [31:0] p,
                            input bit pulse);
    send_sync(w);
    for (int j = 3; j >= 0; j--) send_byte(p[8*j+7 -: 8], pulse);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic drain();
    bus0.byte_ready = 1'b1;
    idle(12);
  endtask

  task automatic expect_rx(input string name, input logic [63:0] w,
                           input int n);
    chk({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk(name, rx_q[i], w[8*(n-1-i)+7 -: 8]);
  endtask

  initial begin
    int base;
    logic [7:0] t;
    bus0.byte_ready = 1'b1;
    idle(2);

    do_reset();
    gap_max = 2;
    rx_q.delete();
    send_frame(16'h1ACF, 32'hDEADBEEF, 1'b0);
    drain();
    expect_rx("lock", {32'h0, 32'hDEADBEEF}, 4);

    do_reset();
    gap_max = 0;
    base = fs1_cnt;
    rx_q.delete();
    send_frame(16'h1ACE, 32'hDEADBEEF, 1'b0);
    drain();
    chk("nearmiss_rx", rx_q.size(), 0);
    chk("nearmiss_err1_lock", fs1_cnt - base, 1);

    do_reset();
    bus0.byte_ready = 1'b0;
    rx_q.delete();
    send_frame(16'h1ACF, 32'hDEADBEEF, 1'b0);
    send_frame(16'h1ACF, 32'h01234567, 1'b0);
    idle(2);
    chk("bp_overflow", ov0, 1);
    chk("bp_valid", bus0.byte_valid, 1);
    drain();
    expect_rx("bp", {32'h0, 32'hDEADBEEF}, 4);
    chk("bp_sticky", ov0, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    tick();
    chk("bp_clr", ov0, 0);

    do_reset();
    gap_max = 1;
    bus0.byte_ready = 1'b0;
    rx_q.delete();
    send_frame(16'h1ACF, 32'hDEADBEEF, 1'b0);
    send_frame(16'h1ACF, 32'hCAFE0123, 1'b1);
    chk("pushpop_ovf", ov0, 0);
    drain();
    expect_rx("pushpop", {32'hDEADBEEF, 32'hCAFE0123}, 8);

    do_reset();
    gap_max = 0;
    bus0.byte_ready = 1'b0;
    rx_q.delete();
    send_sync(16'h1ACF);
    send_byte(8'hDE, 1'b0);
    t = 8'hAD;
    sym(t[7:6], 1'b0);
    sym(t[5:4], 1'b0);
    chk("pre_reset_locked", lk0, 1);
    chk("pre_reset_valid", bus0.byte_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_locked", lk0, 0);
    chk("rst_valid", bus0.byte_valid, 0);
    chk("rst_data", bus0.byte_data, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_ovf", ov0, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    bus0.byte_ready = 1'b1;
    rx_q.delete();
    send_frame(16'h1ACF, 32'h5A3C96F0, 1'b0);
    drain();
    expect_rx("after_rst", {32'h0, 32'h5A3C96F0}, 4);

    do_reset();
    rx_q.delete();
    send_frame(16'hE530, 32'h21524110, 1'b0);
    drain();
    expect_rx("invert", {32'h0, 32'hDEADBEEF}, INV_EN ? 4 : 0);

    do_reset();
    rnd_rdy = 1'b1;
    gap_max = 2;
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 10)) sym(2'($urandom), 1'b0);
      send_frame(($urandom_range(0, 1) != 0) ? 16'h1ACF : 16'hE530,
                 $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
      end
    end
    rnd_rdy = 1'b0;
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
